// File: rtl/dmem_port_arbiter.sv
// Single-port data memory arbiter between the pipeline MEM stage (P) and the DMA/loader (D).
// Optional starvation guard for D is built in with `define DMEM_STARVE_GUARD_EN.
module dmem_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_gnt,
    output logic              p_stall,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              force_d_s;
    logic              p_gnt_s;
    logic              d_gnt_s;
    logic              mem_en_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic              rd_fire_s;
    logic              rd_pend_r;
    logic              rd_owner_r;

`ifdef DMEM_STARVE_GUARD_EN
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0] wait_cnt_r;

    assign force_d_s = (wait_cnt_r == MAX_WAIT_C);

    // Count consecutive cycles D is refused, saturating at MAX_WAIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= 4'd0;
        end else if (d_req & ~d_gnt_s) begin
            if (wait_cnt_r == MAX_WAIT_C) begin
                wait_cnt_r <= wait_cnt_r;
            end else begin
                wait_cnt_r <= wait_cnt_r + 4'd1;
            end
        end else begin
            wait_cnt_r <= 4'd0;
        end
    end
`else
    // MAX_WAIT only matters when the guard is built in; D never overrides P here
    assign force_d_s = 1'b0 & (MAX_WAIT != 0);
`endif

    // Grant selection: P has priority unless the guard forces D through
    always_comb begin
        p_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        if (reset) begin
            p_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end else if (p_req & ~(d_req & force_d_s)) begin
            p_gnt_s = 1'b1;
        end else if (d_req) begin
            d_gnt_s = 1'b1;
        end else begin
            p_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end
    end

    // Memory-side mux from whichever port holds the grant
    always_comb begin
        mem_en_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = {ADDR_W{1'b0}};
        mem_wdata_s = {DATA_W{1'b0}};
        if (p_gnt_s) begin
            mem_en_s    = 1'b1;
            mem_we_s    = p_we;
            mem_addr_s  = p_addr;
            mem_wdata_s = p_wdata;
        end else if (d_gnt_s) begin
            mem_en_s    = 1'b1;
            mem_we_s    = d_we;
            mem_addr_s  = d_addr;
            mem_wdata_s = d_wdata;
        end else begin
            mem_en_s    = 1'b0;
            mem_we_s    = 1'b0;
            mem_addr_s  = {ADDR_W{1'b0}};
            mem_wdata_s = {DATA_W{1'b0}};
        end
    end

    assign rd_fire_s = mem_en_s & ~mem_we_s;

    // Remember a granted read and its owner so the next cycle's data is steered back
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend_r  <= 1'b0;
            rd_owner_r <= 1'b0;
        end else begin
            rd_pend_r <= rd_fire_s;
            if (rd_fire_s) begin
                rd_owner_r <= d_gnt_s;
            end else begin
                rd_owner_r <= rd_owner_r;
            end
        end
    end

    assign p_gnt     = p_gnt_s;
    assign d_gnt     = d_gnt_s;
    assign p_stall   = ~reset & p_req & ~p_gnt_s;
    assign mem_en    = mem_en_s;
    assign mem_we    = mem_we_s;
    assign mem_addr  = mem_addr_s;
    assign mem_wdata = mem_wdata_s;
    assign p_rvalid  = rd_pend_r & ~rd_owner_r;
    assign d_rvalid  = rd_pend_r & rd_owner_r;
    assign p_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed test-plan scenarios plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_dmem_port_arbiter;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 16;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              p_req, p_we, d_req, d_we;
    logic [ADDR_W-1:0] p_addr, d_addr;
    logic [DATA_W-1:0] p_wdata, d_wdata;
    logic              p_gnt, p_stall, p_rvalid, d_gnt, d_rvalid;
    logic [DATA_W-1:0] p_rdata, d_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = 16'h0000;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_gnt(p_gnt), .p_stall(p_stall), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Environment RAM: synchronous, one-cycle read latency
    logic [DATA_W-1:0] ram [256];
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    end

    // Reference model: who wins, what the memory sees, and what data comes back
    logic [DATA_W-1:0] shadow [256];
    logic              m_pend, m_owner_d;
    logic [DATA_W-1:0] m_data;
    logic              e_p_gnt, e_d_gnt, e_stall;
    logic              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
`ifdef DMEM_STARVE_GUARD_EN
    int d_lost;
`endif

    always_comb begin
        logic d_forced;
        d_forced = 1'b0;
`ifdef DMEM_STARVE_GUARD_EN
        d_forced = p_req && d_req && (d_lost >= MAX_WAIT);
`endif
        e_p_gnt = 1'b0; e_d_gnt = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
        if (!reset) begin
            if (p_req && !d_forced)    e_p_gnt = 1'b1;
            else if (d_req)            e_d_gnt = 1'b1;
        end
        if (e_p_gnt) begin e_we = p_we; e_addr = p_addr; e_wdata = p_wdata; end
        if (e_d_gnt) begin e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; end
        e_stall = !reset && p_req && !e_p_gnt;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pend <= 1'b0;
`ifdef DMEM_STARVE_GUARD_EN
            d_lost <= 0;
`endif
        end else begin
            m_pend <= 1'b0;
            if (e_p_gnt || e_d_gnt) begin
                if (e_we) shadow[e_addr] <= e_wdata;
                else begin
                    m_pend    <= 1'b1;
                    m_owner_d <= e_d_gnt;
                    m_data    <= shadow[e_addr];
                end
            end
`ifdef DMEM_STARVE_GUARD_EN
            if (d_req && !e_d_gnt) d_lost <= (d_lost < MAX_WAIT) ? d_lost + 1 : d_lost;
            else d_lost <= 0;
`endif
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        logic [30:0] act, exp;
        act = {p_gnt, d_gnt, p_stall, mem_en, mem_we, mem_addr, mem_wdata, p_rvalid, d_rvalid};
        exp = {e_p_gnt, e_d_gnt, e_stall, e_p_gnt | e_d_gnt, e_we, e_addr, e_wdata,
               m_pend & ~m_owner_d, m_pend & m_owner_d};
        check("outputs", 64'(act), 64'(exp));
        if (m_pend && !m_owner_d) check("p_rdata", 64'(p_rdata), 64'(m_data));
        if (m_pend && m_owner_d)  check("d_rdata", 64'(d_rdata), 64'(m_data));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [19:0] d_pat, s_pat, e_pat;
    logic        pg, dg;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]    <= (i == 16) ? 16'hBEEF : {8'(i), ~8'(i)};
            shadow[i] <= (i == 16) ? 16'hBEEF : {8'(i), ~8'(i)};
        end
        reset = 1'b1;
        p_req = 1'b1; p_we = 1'b0; p_addr = 8'h05; p_wdata = 16'h0000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h06; d_wdata = 16'h0000;

        // Reset held three cycles with both requests high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_quiet", 64'({p_gnt, d_gnt, p_rvalid, d_rvalid, mem_en}), 64'(5'b00000));
        end
        step();
        reset = 1'b0;
        @(negedge clk);
        check("release_p_first", 64'({p_gnt, d_gnt}), 64'(2'b10));
        step();
        p_req = 1'b0; d_req = 1'b0;

        // P read of 0x10
        step();
        p_req = 1'b1; p_we = 1'b0; p_addr = 8'h10;
        @(negedge clk);
        check("p_read_gnt", 64'(p_gnt), 64'(1'b1));
        step();
        p_req = 1'b0;
        @(negedge clk);
        check("p_read_ret", 64'({p_rvalid, d_rvalid, p_rdata}), 64'({2'b10, 16'hBEEF}));

        // D write 0x1234 to 0x20, then P reads it back immediately
        step();
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 16'h1234;
        @(negedge clk);
        check("d_write_gnt", 64'({d_gnt, mem_we}), 64'(2'b11));
        step();
        d_req = 1'b0; d_we = 1'b0;
        p_req = 1'b1; p_addr = 8'h20;
        @(negedge clk);
        check("p_read_after_d_gnt", 64'(p_gnt), 64'(1'b1));
        step();
        p_req = 1'b0;
        @(negedge clk);
        check("p_read_after_d_data", 64'({p_rvalid, p_rdata}), 64'({1'b1, 16'h1234}));

        // Continuous contention for 20 cycles
        step();
        p_req = 1'b1; p_addr = 8'h30; d_req = 1'b1; d_addr = 8'h31;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            d_pat[i] = d_gnt;
            s_pat[i] = p_stall;
        end
`ifdef DMEM_STARVE_GUARD_EN
        for (int i = 0; i < 20; i++) e_pat[i] = ((i % (MAX_WAIT + 1)) == MAX_WAIT);
        if (MAX_WAIT == 4) check("contend_literal", 64'(d_pat), 64'(20'h84210));
`else
        e_pat = 20'h00000;
`endif
        check("contend_d_gnt", 64'(d_pat), 64'(e_pat));
        check("contend_p_stall", 64'(s_pat), 64'(e_pat));
        step();
        p_req = 1'b0; d_req = 1'b0;

        // Reset while a D read is outstanding
        step();
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h40;
        @(negedge clk);
        check("midread_d_gnt", 64'(d_gnt), 64'(1'b1));
        step();
        d_req = 1'b0;
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        @(negedge clk);
        check("midread_no_rvalid", 64'({p_rvalid, d_rvalid}), 64'(2'b00));
        @(negedge clk);
        check("midread_no_rvalid2", 64'({p_rvalid, d_rvalid}), 64'(2'b00));

        // Randomized traffic: P holds until granted, D may withdraw
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            pg = e_p_gnt;
            dg = e_d_gnt;
            step();
            if (!p_req || pg) begin
                p_req   = ($urandom_range(2) != 0);
                p_we    = $urandom_range(1) == 1;
                p_addr  = 8'($urandom_range(15));
                p_wdata = 16'($urandom);
            end
            if (!d_req || dg) begin
                d_req   = ($urandom_range(1) == 1);
                d_we    = $urandom_range(1) == 1;
                d_addr  = 8'($urandom_range(15));
                d_wdata = 16'($urandom);
            end else if ($urandom_range(7) == 0) begin
                d_req = 1'b0;
            end
        end
        p_req = 1'b0; d_req = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Arbitrates one single-port synchronous data memory between the pipeline MEM stage (port P) and the program loader/DMA engine (port D). It grants at most one access per cycle, stalls the pipeline while it is denied, and routes the one-cycle-late read data back to whichever requester issued the read. It sits between the pipelined datapath's MEM stage and the data RAM, and generates the MEM-side component of the core `stall`.

## Interface
- `ADDR_W`, 8: address width; matches the 8-bit branch/data address space.
- `DATA_W`, 16: data width.
- `MAX_WAIT`, 4: contested cycles D may lose before it is forced through. Legal range 1..15. Used only with `DMEM_STARVE_GUARD_EN`.

- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `p_req`  in  1  pipeline access request; held until granted.
- `p_we`  in  1  pipeline write enable; 0 selects a read.
- `p_addr`  in  ADDR_W  pipeline address.
- `p_wdata`  in  DATA_W  pipeline write data.
- `p_gnt`  out  1  pipeline access accepted this cycle.
- `p_stall`  out  1  `p_req & ~p_gnt`.
- `p_rvalid`  out  1  `p_rdata` holds the pipeline's read result.
- `p_rdata`  out  DATA_W  read data returned to the pipeline.
- `d_req`, `d_we`, `d_addr`, `d_wdata`, `d_gnt`, `d_rvalid`, `d_rdata`: same meanings and widths as the P signals, for the DMA/loader port.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; valid the cycle after a read strobe.

## Operation
- **Handshake.** A transfer occurs in any cycle with `x_req & x_gnt`.
  - Grants are combinational from the requests and the registered arbitration state.
  - A requester keeps `req`, `we`, `addr` and `wdata` stable until it is granted.
- **Memory side.**
  - `mem_en = p_gnt | d_gnt`.
  - `mem_we`, `mem_addr` and `mem_wdata` are muxed from the granted port.
  - With no grant, `mem_en = 0`, `mem_we = 0`, and address/data are 0.
- **Arbitration.**
  - Only P requests: P granted.
  - Only D requests: D granted.
  - Both request: P wins, except as modified under Configuration.
  - `p_gnt` and `d_gnt` are never high together.
- **Read return.**
  - State: `rd_pend` (1 bit) and `rd_owner` (1 bit).
  - A granted read sets `rd_pend` and records the owner.
  - In the following cycle, exactly one of `p_rvalid`/`d_rvalid` pulses for one cycle. `p_rdata` and `d_rdata` both carry `mem_rdata`.
  - A new read granted in that same cycle re-arms `rd_pend`, so back-to-back reads return on consecutive cycles.
  - Writes produce no `rvalid`.
- **Wait counter.**
  - `wait_cnt` has 4 bits.
  - It increments in each cycle with `d_req & ~d_gnt`, saturating at `MAX_WAIT`.
  - It clears in any cycle D is granted or `d_req` is low.

## Timing
- Grant latency: 0 cycles; grant is in the same cycle as the request when that port wins.
- Read latency: 1 cycle from grant to `rvalid`.
- Write completion: at the rising edge that ends the grant cycle.
- Throughput: 1 access per cycle in total across both ports.
- **Reset values:**
  - All grants, `p_stall`, both `rvalid`s, `mem_en` and `mem_we`: 0.
  - `p_rdata`/`d_rdata` follow `mem_rdata` (don't-care).
  - `rd_pend`, `rd_owner` and `wait_cnt`: 0.
- **Reset mid-read:** asserting `reset` while `rd_pend` = 1 drops the return. No `rvalid` appears after reset deasserts.
- **Request withdrawn before grant:** illegal for P. For D, withdrawing clears `wait_cnt`.

## Configuration
- **`DMEM_STARVE_GUARD_EN` defined:**
  - On contention, if `wait_cnt == MAX_WAIT`, D wins and P stalls for that cycle.
  - `wait_cnt` then clears, so P wins the next `MAX_WAIT` contested cycles.
- **`DMEM_STARVE_GUARD_EN` undefined:**
  - Strict P priority; D can starve indefinitely.
  - `wait_cnt` logic is removed, and `MAX_WAIT` is ignored.

## Test plan
- **Reset:** hold `reset` 3 cycles with both requests high. Required: all grants, `rvalid`s and `mem_en` = 0. Release: P granted first cycle.
- **P read:** P reads 0x10 while memory holds 0xBEEF there. Required: `p_gnt`=1 in cycle N; `p_rvalid`=1 and `p_rdata`=0xBEEF in N+1; `d_rvalid` stays 0.
- **D write then P read, back-to-back:** D writes 0x1234 to 0x20 in cycle N; P reads 0x20 in N+1. Required: `p_rdata`=0x1234 in N+2.
- **Contention, guard defined, `MAX_WAIT`=4:** both request continuously. Required pattern: P,P,P,P,D, repeating. `p_stall`=1 only on the D cycles.
- **Contention, guard undefined:** both request for 20 cycles. Required: `d_gnt` never asserts and `p_stall` stays 0.
- **Reset mid-read:** grant a D read, then pulse `reset` before the next edge. Required: no `d_rvalid` after reset is released.
